// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing a single ALU between NumReq requesters.
// Also holds the rvcpu package and the alu it wraps, so the block stands alone.

package rvcpu;
  typedef enum logic [3:0] {
    alu_add, alu_sll, alu_slt, alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;
endpackage

module alu #(
  parameter int Width = 32
) (
  input  rvcpu::alu_op_t    op,
  input  logic [Width-1:0]  a,
  input  logic [Width-1:0]  b,
  input  logic              invert_b,
  output logic [Width-1:0]  res,
  output rvcpu::alu_flags_t flags
);
  localparam int ShW = $clog2(Width);

  logic [Width-1:0] b_eff;
  logic [Width:0]   sum;

  assign b_eff = invert_b ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{Width{1'b0}}, invert_b};

  // alu_slt is left to the caller; res is just zero for it here
  always_comb begin
    res   = '0;
    flags = '0;
    case (op)
      rvcpu::alu_add: res = sum[Width-1:0];
      rvcpu::alu_and: res = a & b_eff;
      rvcpu::alu_or:  res = a | b_eff;
      rvcpu::alu_xor: res = a ^ b_eff;
      rvcpu::alu_sll: res = a << b[ShW-1:0];
      rvcpu::alu_srl: res = a >> b[ShW-1:0];
      rvcpu::alu_sra: res = Width'($signed(a) >>> b[ShW-1:0]);
      default:        res = '0;
    endcase
    flags.zero     = (res == '0);
    flags.negative = res[Width-1];
    if (op == rvcpu::alu_add) begin
      flags.carry    = sum[Width];
      flags.overflow = (a[Width-1] == b_eff[Width-1]) && (sum[Width-1] != a[Width-1]);
    end
  end
endmodule

module alu_share_arbiter #(
  parameter int Width  = 32,
  parameter int NumReq = 3
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NumReq-1:0]                        req_valid,
  output logic [NumReq-1:0]                        req_ready,
  input  logic [NumReq*$bits(rvcpu::alu_op_t)-1:0] req_op,
  input  logic [NumReq*Width-1:0]                  req_a,
  input  logic [NumReq*Width-1:0]                  req_b,
  input  logic [NumReq-1:0]                        req_invert_b,
  output logic [NumReq-1:0]                        rsp_valid,
  input  logic [NumReq-1:0]                        rsp_ready,
  output logic [Width-1:0]                         rsp_res,
  output rvcpu::alu_flags_t                        rsp_flags
);
  localparam int OpW  = $bits(rvcpu::alu_op_t);
  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [IdxW-1:0]   rr_last, owner, grant, cand;
  logic              grant_valid;
  rvcpu::alu_op_t    op_q, alu_op;
  logic [Width-1:0]  a_q, b_q, res_q, alu_res;
  logic              inv_q, alu_inv, lt;
  rvcpu::alu_flags_t alu_flags, flags_q;
  logic [NumReq-1:0] rsp_valid_q;

  // Scan from the requester after the last winner, wrapping around
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(rr_last) + k) % NumReq);
      if (!grant_valid && req_valid[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_valid) req_ready[grant] = 1'b1;
  end

  // SLT runs as a-b; the sign fix-up handles operands of opposite sign
  assign alu_op  = (op_q == rvcpu::alu_slt) ? rvcpu::alu_add : op_q;
  assign alu_inv = (op_q == rvcpu::alu_slt) ? 1'b1 : inv_q;
  assign lt      = (a_q[Width-1] != b_q[Width-1]) ? a_q[Width-1] : alu_res[Width-1];

  alu #(.Width(Width)) u_alu (
    .op       (alu_op),
    .a        (a_q),
    .b        (b_q),
    .invert_b (alu_inv),
    .res      (alu_res),
    .flags    (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_last     <= IdxW'(NumReq - 1);
      owner       <= '0;
      op_q        <= rvcpu::alu_add;
      a_q         <= '0;
      b_q         <= '0;
      inv_q       <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: if ((req_valid & req_ready) != '0) begin
          op_q    <= rvcpu::alu_op_t'(req_op[int'(grant)*OpW +: OpW]);
          a_q     <= req_a[int'(grant)*Width +: Width];
          b_q     <= req_b[int'(grant)*Width +: Width];
          inv_q   <= req_invert_b[grant];
          owner   <= grant;
          rr_last <= grant;
          state   <= EXEC;
        end
        EXEC: begin
          res_q       <= (op_q == rvcpu::alu_slt) ? {{(Width-1){1'b0}}, lt} : alu_res;
          flags_q     <= alu_flags;
          rsp_valid_q <= NumReq'(1) << owner;
          state       <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid_q <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a negedge monitor models grants and
// queues expected responses, directed tasks cover the corner cases.
module tb_alu_share_arbiter;
  localparam int W   = 32;
  localparam int N   = 3;
  localparam int OPW = $bits(rvcpu::alu_op_t);

  typedef struct {
    int                owner;
    logic [W-1:0]      res;
    rvcpu::alu_flags_t flags;
    int                acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready, req_invert_b, rsp_valid, rsp_ready;
  logic [N*OPW-1:0]  req_op;
  logic [N*W-1:0]    req_a, req_b;
  logic [W-1:0]      rsp_res;
  rvcpu::alu_flags_t rsp_flags;

  exp_t q[$];
  int   accept_owner[$];
  int   accept_cycle[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   busy = 1'b0;
  int   rr_model = N - 1;

  int                mon_g, mon_c;
  logic [N-1:0]      mon_ready;
  exp_t              mon_e;
  logic [W-1:0]      bp_res;
  rvcpu::alu_flags_t bp_flags;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter #(.Width(W), .NumReq(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_invert_b (req_invert_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour; slt flags are those of a-b, its result is a signed compare
  function automatic void model(input rvcpu::alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic inv, output logic [W-1:0] res, output rvcpu::alu_flags_t fl);
    logic         i;
    logic [W-1:0] bx, src;
    logic [W:0]   s;
    i   = (op == rvcpu::alu_slt) ? 1'b1 : inv;
    bx  = i ? ~b : b;
    s   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, i};
    fl  = '0;
    res = '0;
    case (op)
      rvcpu::alu_add: res = s[W-1:0];
      rvcpu::alu_slt: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      rvcpu::alu_and: res = a & bx;
      rvcpu::alu_or:  res = a | bx;
      rvcpu::alu_xor: res = a ^ bx;
      default:        res = '0;
    endcase
    src = (op == rvcpu::alu_add || op == rvcpu::alu_slt) ? s[W-1:0] : res;
    fl.zero     = (src == '0);
    fl.negative = src[W-1];
    if (op == rvcpu::alu_add || op == rvcpu::alu_slt) begin
      fl.carry    = s[W];
      fl.overflow = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      busy     = 1'b0;
      rr_model = N - 1;
    end else begin
      mon_ready = '0;
      mon_g     = -1;
      if (!busy) begin
        for (int k = 1; k <= N; k++) begin
          mon_c = (rr_model + k) % N;
          if (mon_g < 0 && req_valid[mon_c]) mon_g = mon_c;
        end
      end
      if (mon_g >= 0) mon_ready[mon_g] = 1'b1;
      checkOutput("req_ready", req_ready, mon_ready);
      if (mon_g >= 0) begin
        model(rvcpu::alu_op_t'(req_op[mon_g*OPW +: OPW]), req_a[mon_g*W +: W], req_b[mon_g*W +: W],
              req_invert_b[mon_g], mon_e.res, mon_e.flags);
        mon_e.owner = mon_g;
        mon_e.acc   = cyc;
        q.push_back(mon_e);
        busy     = 1'b1;
        rr_model = mon_g;
        accept_owner.push_back(mon_g);
        accept_cycle.push_back(cyc);
      end
      if (q.size() == 0) begin
        checkOutput("rsp_idle", rsp_valid, '0);
      end else if (cyc - q[0].acc < 2) begin
        checkOutput("rsp_early", rsp_valid, '0);
      end else begin
        checkOutput("rsp_valid", rsp_valid, N'(1) << q[0].owner);
        checkOutput("rsp_res", rsp_res, q[0].res);
        checkOutput("rsp_flags", rsp_flags, q[0].flags);
        if (rsp_ready[q[0].owner]) begin
          void'(q.pop_front());
          busy = 1'b0;
        end
      end
    end
  end

  task automatic setReq(input int i, input rvcpu::alu_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic inv);
    req_op[i*OPW +: OPW] = op;
    req_a[i*W +: W]      = a;
    req_b[i*W +: W]      = b;
    req_invert_b[i]      = inv;
  endtask

  // Raise one request, wait for its grant, drop valid right after the accepting edge
  task automatic applyStimulus(input int i, input rvcpu::alu_op_t op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic inv);
    bit got = 1'b0;
    setReq(i, op, a, b, inv);
    req_valid[i] = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) checkOutput("accept_timeout", req_ready[i], 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic waitIdle();
    for (int t = 0; t < 200 && (q.size() != 0 || busy); t++) @(negedge clk);
    checkOutput("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid    = '0;
    req_invert_b = '0;
    req_op       = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = '1;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, '0);
    checkOutput("reset_rsp_valid", rsp_valid, '0);
    checkOutput("reset_rsp_res", rsp_res, '0);
    checkOutput("reset_rsp_flags", rsp_flags, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All three requesters hold valid: grants must rotate 0,1,2,0 three cycles apart
    accept_owner.delete();
    accept_cycle.delete();
    setReq(0, rvcpu::alu_add, 32'd10, 32'd1, 1'b0);
    setReq(1, rvcpu::alu_add, 32'd20, 32'd2, 1'b0);
    setReq(2, rvcpu::alu_add, 32'd30, 32'd3, 1'b1);
    req_valid = '1;
    for (int t = 0; t < 60 && accept_owner.size() < 4; t++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    checkOutput("rr_count", accept_owner.size(), 4);
    if (accept_owner.size() >= 4) begin
      checkOutput("rr_order0", accept_owner[0], 0);
      checkOutput("rr_order1", accept_owner[1], 1);
      checkOutput("rr_order2", accept_owner[2], 2);
      checkOutput("rr_order3", accept_owner[3], 0);
      for (int k = 0; k < 3; k++)
        checkOutput("rr_spacing", accept_cycle[k+1] - accept_cycle[k], 3);
    end
    waitIdle();

    // Single add on requester 1 with directed timing checks
    applyStimulus(1, rvcpu::alu_add, 32'd5, 32'd7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_valid", rsp_valid, 3'b010);
    checkOutput("single_res", rsp_res, 32'd12);
    checkOutput("single_zero", rsp_flags.zero, 1'b0);
    @(posedge clk); #1;
    checkOutput("single_drop", rsp_valid, '0);
    waitIdle();

    applyStimulus(0, rvcpu::alu_add, 32'd3, 32'd3, 1'b1);
    waitIdle();
    applyStimulus(2, rvcpu::alu_slt, 32'hFFFF_FFFF, 32'd1, 1'b0);
    waitIdle();
    applyStimulus(2, rvcpu::alu_slt, 32'd1, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    applyStimulus(2, rvcpu::alu_slt, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    waitIdle();
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0:       applyStimulus(k % N, rvcpu::alu_xor, $urandom, $urandom, 1'b0);
        1:       applyStimulus(k % N, rvcpu::alu_and, $urandom, $urandom, 1'b0);
        2:       applyStimulus(k % N, rvcpu::alu_add, $urandom, $urandom, 1'($urandom_range(1)));
        default: applyStimulus(k % N, rvcpu::alu_slt, $urandom, $urandom, 1'b0);
      endcase
      waitIdle();
    end

    // Requester 2 stalls its response while requester 0 waits
    rsp_ready = 3'b011;
    model(rvcpu::alu_add, 32'd100, 32'd23, 1'b0, bp_res, bp_flags);
    applyStimulus(2, rvcpu::alu_add, 32'd100, 32'd23, 1'b0);
    setReq(0, rvcpu::alu_xor, 32'hA5A5_0F0F, 32'h0000_FFFF, 1'b0);
    req_valid[0] = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", rsp_valid, 3'b100);
      checkOutput("bp_res", rsp_res, bp_res);
      checkOutput("bp_ready", req_ready, '0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    checkOutput("bp_ready_hs", req_ready, '0);
    @(negedge clk);
    checkOutput("bp_grant0", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitIdle();

    // Asynchronous reset while the op sits in EXEC
    applyStimulus(1, rvcpu::alu_add, 32'd9, 32'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, '0);
    checkOutput("rst_rsp_valid", rsp_valid, '0);
    checkOutput("rst_rsp_res", rsp_res, '0);
    checkOutput("rst_rsp_flags", rsp_flags, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_stale", rsp_valid, '0);
    end
    @(posedge clk); #1;
    setReq(0, rvcpu::alu_or, 32'h1234_0000, 32'h0000_5678, 1'b0);
    setReq(1, rvcpu::alu_add, 32'd1, 32'd1, 1'b0);
    req_valid = 3'b011;
    @(negedge clk);
    checkOutput("rst_grant0", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = '0;
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
